sc_out_collector: RTL and testbench
===================================

Name: sc_out_collector

Overview:
- Downstream stage of aes_sbox_stream_cipher.
- Snoops the cipher's input stream (din_valid / txt_in_char) and aligns each character with the cipher result (txt_out_char / dout_ready).
- Selects ciphertext for ASCII letters and the original character for everything else, then buffers the result in a byte FIFO with a valid/ready sink interface.
- Replaces the bench-side letter/non-letter selection and queue with RTL so encrypted files can be streamed out by hardware.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
- CIPHER_LAT, 1, cipher latency in cycles from din_valid to dout_ready; 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- din_valid  in  1  snoop of the cipher input valid.
- txt_in_char  in  8  snoop of the cipher input character.
- txt_out_char  in  8  cipher output character.
- dout_ready  in  1  cipher output valid strobe.
- flush  in  1  synchronous clear of the FIFO and alignment pipeline.
- out_valid  out  1  FIFO head is valid.
- out_char  out  8  FIFO head byte.
- out_ready  in  1  sink accepts the head byte.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- sync_err  out  1  sticky: a letter reached the select stage while dout_ready was low.

Behaviour:
- Reset (async, rst_n=0): pipeline valid bits, pointers, level, overflow and sync_err all 0; out_valid=0; out_char=0.
- Alignment pipeline:
  - CIPHER_LAT registered stages of {valid, char}.
  - Stage 0 captures din_valid / txt_in_char on each rising edge.
  - The last stage is the "select" stage, aligned with the cycle the cipher presents its output for that character.
- Letter classification: 0x41..0x5A or 0x61..0x7A (the same A-Z / a-z ranges the bench uses).
- Select stage, when valid:
  - Letter: write byte = txt_out_char. If dout_ready=0, still write txt_out_char and set sync_err.
  - Non-letter: write byte = the delayed plain character; dout_ready is ignored.
- The push happens in the select-stage cycle; the byte is visible at the FIFO head the following cycle. Total latency din_valid -> out_valid (FIFO empty) = CIPHER_LAT+1 cycles.
- FIFO:
  - First-word-fall-through: out_char = mem[rd_ptr] whenever out_valid=1, and 0 when empty.
  - Pointers are log2(DEPTH)+1 bits wide; empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap modulo 2*DEPTH naturally.
- Pop occurs when out_valid && out_ready.
- Full with push and no pop: the byte is dropped, overflow is set, and level stays DEPTH.
- Full with push and pop in the same cycle: both are accepted and level is unchanged.
- Empty with push and out_ready=1: no pop that cycle (FWFT head is not yet valid).
- level updates as +1 (push only), -1 (pop only), or unchanged.
- flush=1:
  - Next cycle: pointers, level and pipeline valid bits are 0.
  - A push or pop in the flush cycle is discarded.
  - Sticky flags are NOT cleared.
- Sticky flags clear only on reset.
- Characters with din_valid=0 are never written. Gaps in din_valid produce gaps in pushes, with order preserved.

Optional Feature:
- SC_OUT_COLLECTOR_STATS_EN defined adds three outputs:
  - letter_cnt (16 bits): count of letters pushed.
  - passthru_cnt (16 bits): count of non-letters pushed.
  - drop_cnt (16 bits): count of dropped bytes.
- Each counter saturates at 0xFFFF, is reset by rst_n, and is cleared by flush.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package sc_pkg holds:
  - Constants UPPERCASE_A_CHAR=8'h41, UPPERCASE_Z_CHAR=8'h5A, LOWERCASE_A_CHAR=8'h61, LOWERCASE_Z_CHAR=8'h7A.
  - Typedef char_t = logic [7:0].
  - Function is_letter(char_t), shared with the cipher and the benches.
- One sub-module, sc_byte_fifo (parameter DEPTH; FWFT; push/pop/flush; full/empty/level), instantiated once.
- The alignment pipeline and select logic live in the top module.

Test Plan:
- Reset mid-stream: push 3 bytes, assert rst_n=0 asynchronously between edges -> out_valid, level, overflow and sync_err are 0 immediately; out_char=0.
- Mixed stream, CIPHER_LAT=1, key 8'h12, with cipher model:
  - Stimulus: "Ab 1z" with out_ready=1.
  - Output order: cipher('A'), cipher('b'), 0x20, 0x31, cipher('z').
  - First out_valid occurs 2 cycles after the first din_valid.
- Fill and overflow, DEPTH=16, out_ready=0:
  - 17 valid chars -> level=16 and overflow=1.
  - The 17th byte is absent on drain; the drained bytes match the first 16 in order.
- Full with simultaneous push/pop: with level=16, one cycle with din-derived push and out_ready=1 -> level stays 16, overflow stays 0, and the head advances by one.
- Sync error: letter 'q' presented with dout_ready forced 0 at the select stage -> sync_err=1 and txt_out_char is written. A following non-letter '.' with dout_ready=0 writes 0x2E and does not set sync_err anew.
- Flush and wrap: push 10 bytes, pop 10, push 12 (pointers wrap), then flush=1 -> next cycle level=0 and out_valid=0; sticky flags are unchanged. With SC_OUT_COLLECTOR_STATS_EN defined, the counters read 0 after flush.

Source files
------------

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared character constants, types and helpers for the stream-cipher collector
package sc_pkg;

    typedef logic [7:0] char_t;

    localparam char_t UPPERCASE_A_CHAR = 8'h41;
    localparam char_t UPPERCASE_Z_CHAR = 8'h5A;
    localparam char_t LOWERCASE_A_CHAR = 8'h61;
    localparam char_t LOWERCASE_Z_CHAR = 8'h7A;

    function automatic logic is_letter(input char_t c);
        return ((c >= UPPERCASE_A_CHAR) && (c <= UPPERCASE_Z_CHAR)) ||
               ((c >= LOWERCASE_A_CHAR) && (c <= LOWERCASE_Z_CHAR));
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sc_byte_fifo.sv
// rtl/sc_byte_fifo.sv - first-word-fall-through byte FIFO with flush and drop indication
module sc_byte_fifo
    import sc_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  char_t                  push_data,
    input  logic                   pop,
    input  logic                   flush,
    output char_t                  head,
    output logic                   empty,
    output logic                   dropped,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    char_t       r_mem [DEPTH];

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty && !flush;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push && !flush && (!w_full || w_do_pop);
    assign dropped   = push && !flush && w_full && !w_do_pop;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign head      = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sc_out_collector.sv
// rtl/sc_out_collector.sv - aligns cipher output with snooped plaintext and queues selected bytes
// Optional counters are enabled with SC_OUT_COLLECTOR_STATS_EN.
module sc_out_collector
    import sc_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CIPHER_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   din_valid,
    input  logic [7:0]             txt_in_char,
    input  logic [7:0]             txt_out_char,
    input  logic                   dout_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [7:0]             out_char,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   sync_err
`ifdef SC_OUT_COLLECTOR_STATS_EN
    ,
    output logic [15:0]            letter_cnt,
    output logic [15:0]            passthru_cnt,
    output logic [15:0]            drop_cnt
`endif
);

    logic [CIPHER_LAT-1:0] r_vld;
    char_t                 r_chr [CIPHER_LAT];
    logic                  r_overflow;
    logic                  r_sync_err;

    logic  w_sel_vld;
    char_t w_sel_chr;
    logic  w_sel_letter;
    char_t w_wr_byte;
    logic  w_empty;
    logic  w_dropped;
    logic  w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < CIPHER_LAT; i++) r_chr[i] <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= din_valid;
            r_chr[0] <= txt_in_char;
            for (int i = 1; i < CIPHER_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_chr[i] <= r_chr[i-1];
            end
        end
    end

    // The last stage lines up with the cycle the cipher presents this character's result.
    assign w_sel_vld    = r_vld[CIPHER_LAT-1];
    assign w_sel_chr    = r_chr[CIPHER_LAT-1];
    assign w_sel_letter = is_letter(w_sel_chr);
    assign w_wr_byte    = w_sel_letter ? txt_out_char : w_sel_chr;

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

    sc_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_sel_vld),
        .push_data (w_wr_byte),
        .pop       (w_pop),
        .flush     (flush),
        .head      (out_char),
        .empty     (w_empty),
        .dropped   (w_dropped),
        .level     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_dropped) r_overflow <= 1'b1;
            if (w_sel_vld && w_sel_letter && !dout_ready) r_sync_err <= 1'b1;
        end
    end

    assign overflow = r_overflow;
    assign sync_err = r_sync_err;

`ifdef SC_OUT_COLLECTOR_STATS_EN
    logic [15:0] r_letter_cnt;
    logic [15:0] r_passthru_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_accept;

    assign w_accept = w_sel_vld && !flush && !w_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_letter_cnt   <= '0;
            r_passthru_cnt <= '0;
            r_drop_cnt     <= '0;
        end else if (flush) begin
            r_letter_cnt   <= '0;
            r_passthru_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_accept && w_sel_letter)  r_letter_cnt   <= sat_inc16(r_letter_cnt);
            if (w_accept && !w_sel_letter) r_passthru_cnt <= sat_inc16(r_passthru_cnt);
            if (w_dropped)                 r_drop_cnt     <= sat_inc16(r_drop_cnt);
        end
    end

    assign letter_cnt   = r_letter_cnt;
    assign passthru_cnt = r_passthru_cnt;
    assign drop_cnt     = r_drop_cnt;
`endif

endmodule

// File: tb/tb_sc_out_collector.sv
// tb/tb_sc_out_collector.sv - directed self-checking bench for sc_out_collector
module tb_sc_out_collector;

    logic       clk;
    logic       rst_n;
    logic       din_valid;
    logic [7:0] txt_in_char;
    logic [7:0] txt_out_char;
    logic       dout_ready;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_char;
    logic       out_ready;
    logic [4:0] level;
    logic       overflow;
    logic       sync_err;
`ifdef SC_OUT_COLLECTOR_STATS_EN
    logic [15:0] letter_cnt;
    logic [15:0] passthru_cnt;
    logic [15:0] drop_cnt;
`endif

    int n_vec;
    int n_miss;

    logic       p_v;
    logic [7:0] p_c;

    sc_out_collector #(.DEPTH(16), .CIPHER_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid    (din_valid),
        .txt_in_char  (txt_in_char),
        .txt_out_char (txt_out_char),
        .dout_ready   (dout_ready),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_char     (out_char),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .sync_err     (sync_err)
`ifdef SC_OUT_COLLECTOR_STATS_EN
        ,
        .letter_cnt   (letter_cnt),
        .passthru_cnt (passthru_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in cipher with key 8'h12: result appears one cycle after its input.
    function automatic logic [7:0] enc(input logic [7:0] c);
        return c ^ 8'h12;
    endfunction

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c, input logic ordy, input logic kill);
        din_valid    = v;
        txt_in_char  = c;
        txt_out_char = enc(p_c);
        dout_ready   = p_v & ~kill;
        out_ready    = ordy;
        @(posedge clk);
        #1;
        p_v = v;
        p_c = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b0; txt_in_char = 8'h00; txt_out_char = 8'h00;
        dout_ready = 1'b0; out_ready = 1'b0; flush = 1'b0;
        p_v = 1'b0; p_c = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [7:0] mix_in  [5];
    logic [7:0] mix_exp [5];
    int first_t;
    int n_out;

    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0;
        din_valid = 1'b0; txt_in_char = 8'h00; txt_out_char = 8'h00;
        dout_ready = 1'b0; out_ready = 1'b0; flush = 1'b0;
        p_v = 1'b0; p_c = 8'h00;
        mix_in  = '{8'h41, 8'h62, 8'h20, 8'h31, 8'h7A};
        mix_exp = '{8'h53, 8'h70, 8'h20, 8'h31, 8'h68};

        #2;
        expect_eq("rst_out_valid", out_valid, 0);
        expect_eq("rst_level", level, 0);
        expect_eq("rst_out_char", out_char, 0);
        expect_eq("rst_overflow", overflow, 0);
        expect_eq("rst_sync_err", sync_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reset asserted between edges while bytes are queued
        for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        expect_eq("mid_level_before", level, 3);
        #3;
        rst_n = 1'b0;
        #1;
        expect_eq("mid_out_valid", out_valid, 0);
        expect_eq("mid_level", level, 0);
        expect_eq("mid_out_char", out_char, 0);
        expect_eq("mid_overflow", overflow, 0);
        expect_eq("mid_sync_err", sync_err, 0);
        do_reset();

        // mixed letters and non-letters, sink always ready
        first_t = -1;
        n_out = 0;
        for (int t = 0; t < 10; t++) begin
            if (t < 5) step(1'b1, mix_in[t], 1'b1, 1'b0);
            else       step(1'b0, 8'h00, 1'b1, 1'b0);
            if (out_valid) begin
                if (first_t < 0) first_t = t + 1;
                if (n_out < 5) expect_eq("mix_byte", out_char, mix_exp[n_out]);
                n_out++;
            end
        end
        expect_eq("mix_first_valid", first_t, 2);
        expect_eq("mix_count", n_out, 5);
        expect_eq("mix_sync_err", sync_err, 0);

        // full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h23, 1'b0, 1'b0);
        expect_eq("full_level", level, 16);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_eq("pp_level", level, 16);
        expect_eq("pp_overflow", overflow, 0);
        expect_eq("pp_head", out_char, 8'h31);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_eq("pp_last_byte", out_char, 8'h23);
        expect_eq("pp_last_level", level, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_eq("pp_empty", out_valid, 0);

        // fill past capacity: 17th byte dropped
        for (int i = 0; i < 17; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        expect_eq("ovf_level", level, 16);
        expect_eq("ovf_flag", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            expect_eq("ovf_drain", out_char, 8'h30 + 8'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        expect_eq("ovf_drained_valid", out_valid, 0);
        expect_eq("ovf_drained_level", level, 0);

        // letter at select stage while cipher strobe is low
        step(1'b1, 8'h71, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        expect_eq("sync_flag", sync_err, 1);
        expect_eq("sync_byte", out_char, 8'h63);
        step(1'b1, 8'h2E, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        expect_eq("sync_level", level, 2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_eq("sync_dot_byte", out_char, 8'h2E);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_eq("sync_empty", out_valid, 0);

        // wrap pointers, then flush; sticky flags must survive
        for (int i = 0; i < 10; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        expect_eq("wrap_level10", level, 10);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_eq("wrap_level0", level, 0);
        for (int i = 0; i < 12; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        expect_eq("wrap_level12", level, 12);
        expect_eq("wrap_head", out_char, 8'h53);
        flush = 1'b1;
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        flush = 1'b0;
        expect_eq("flush_level", level, 0);
        expect_eq("flush_out_valid", out_valid, 0);
        expect_eq("flush_out_char", out_char, 0);
        expect_eq("flush_overflow", overflow, 1);
        expect_eq("flush_sync_err", sync_err, 1);
`ifdef SC_OUT_COLLECTOR_STATS_EN
        expect_eq("flush_letter_cnt", letter_cnt, 0);
        expect_eq("flush_passthru_cnt", passthru_cnt, 0);
        expect_eq("flush_drop_cnt", drop_cnt, 0);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0);
        expect_eq("flush_pipe_cleared", level, 0);
        step(1'b1, 8'h21, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        expect_eq("post_flush_byte", out_char, 8'h21);
        expect_eq("post_flush_level", level, 1);

        // non-letter with strobe low writes plain byte and leaves sync_err clear
        do_reset();
        step(1'b1, 8'h2E, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        expect_eq("dot_sync_err", sync_err, 0);
        expect_eq("dot_byte", out_char, 8'h2E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
